adder_share_arbiter: RTL and testbench

//  Shares one combinational adder_64 between N_REQ requesters (e.g. PC+4, branch target, address calc).

---
 rtl/adder_arb_pkg.sv | 29 ++
 rtl/adder_64.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/adder_share_arbiter.sv | 116 +++++++++++
 tb/tb_adder_share_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder-sharing arbiter slice.
// Holds the result-flag layout and the helper that derives flags from adder outputs.
package adder_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int ID_W_DEF  = 2;
    localparam int CNT_W_DEF = 32;
    localparam int FLAG_W    = 4;

    typedef struct packed {
        logic neg;
        logic zero;
        logic ovf;
        logic cout;
    } add_flags_t;

    // c63 is the carry out of the MSB, c62 the carry into it; signed overflow is their disagreement.
    function automatic add_flags_t calc_flags(input logic [63:0] sum,
                                              input logic        c63,
                                              input logic        c62);
        add_flags_t f;
        f.neg  = sum[63];
        f.zero = (sum == 64'd0);
        f.ovf  = c63 ^ c62;
        f.cout = c63;
        return f;
    endfunction

endpackage

// File: rtl/adder_64.sv
// Combinational 64-bit adder with carry-in tied to zero.
// Exposes the carries out of bits 63 and 62 for overflow detection.
module adder_64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_sum,
    output logic        o_c63,
    output logic        o_c62
);

    logic [64:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum  = w_full[63:0];
    assign o_c63  = w_full[64];
    // Carry into bit 63 recovered from the sum bit and its operand bits.
    assign o_c62  = i_a[63] ^ i_b[63] ^ w_full[63];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from i_ptr upward (mod N) for the first request.
// Reusable by any scheduler that owns its own pointer register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Rotating priority search starting at the pointer.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((int'(i_ptr) + k) % N);
            if (i_en && i_req[w_idx] && !w_found) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One shared 64-bit adder time-multiplexed among N_REQ requesters with round-robin grant
// and a single registered, id-tagged response slot.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*64-1:0] req_a,
    input  logic [N_REQ*64-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [63:0]         rsp_sum,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic [CNT_W-1:0]    op_count
);

    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [63:0]      r_rsp_sum;
    add_flags_t       r_rsp_flags;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_op_count;

    logic             w_slot_free;
    logic             w_arb_en;
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_accept;
    logic             w_rsp_done;
    logic [63:0]      w_op_a;
    logic [63:0]      w_op_b;
    logic [63:0]      w_sum;
    logic             w_c63;
    logic             w_c62;

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    // Gating with reset_n keeps req_ready low for the whole reset window.
    assign w_arb_en    = w_slot_free && reset_n;
    assign w_accept    = |(req_valid & w_gnt);
    assign w_rsp_done  = r_rsp_valid && rsp_ready;

    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr_arbiter (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_arb_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_op_a = req_a[{w_gnt_idx, 6'd0} +: 64];
    assign w_op_b = req_b[{w_gnt_idx, 6'd0} +: 64];

    adder_64 u_adder_64 (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_sum (w_sum),
        .o_c63 (w_c63),
        .o_c62 (w_c62)
    );

    // Response slot: reload on accept, clear on handshake, hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= 64'd0;
            r_rsp_flags <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_sum   <= w_sum;
            r_rsp_flags <= calc_flags(w_sum, w_c63, w_c62);
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    // Round-robin pointer advances past the winner only on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Completed-handshake counter, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count <= '0;
        end else if (w_rsp_done) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end else begin
            r_op_count <= r_op_count;
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_flags = r_rsp_flags;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: stimulus predicts grants and pushes expected
// responses; an independent monitor pops and compares whenever the DUT presents a result.
module tb_adder_share_arbiter;
    import adder_arb_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_sum;
    logic [3:0]   rsp_flags;
    logic [31:0]  op_count;

    logic [3:0]   w2_req_ready;
    logic         w2_rsp_valid;
    logic [1:0]   w2_rsp_id;
    logic [63:0]  w2_rsp_sum;
    logic [3:0]   w2_rsp_flags;
    logic [1:0]   w2_op_count;

    always #5 clk = ~clk;

    adder_share_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_flags(rsp_flags), .op_count(op_count)
    );

    // Narrow-counter copy so the wrap to zero is reached within a short run.
    adder_share_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(2)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(w2_req_ready), .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w2_rsp_id),
        .rsp_sum(w2_rsp_sum), .rsp_flags(w2_rsp_flags), .op_count(w2_op_count)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] sum;
        logic [3:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] e_sum[4];
    logic [3:0]  e_flags[4];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr    = 0;
    bit          m_valid  = 1'b0;
    logic [31:0] m_count  = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] s, input logic [3:0] f);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        e_sum[i]   = s;
        e_flags[i] = f;
    endtask

    // One clock cycle: drive, predict the grant, check, then advance the model past the edge.
    task automatic cycle(input logic [3:0] v, input logic rr);
        int         g;
        logic [3:0] eg;
        exp_t       e;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        #1;
        g = -1;
        if (!m_valid || rr) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("req_ready", {60'd0, req_ready}, {60'd0, eg});
        check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
        check("op_count", {32'd0, op_count}, {32'd0, m_count});
        check("op_count_wrap", {62'd0, w2_op_count}, {62'd0, m_count[1:0]});
        if (g >= 0) begin
            e.id    = g[1:0];
            e.sum   = e_sum[g];
            e.flags = e_flags[g];
            exp_q.push_back(e);
            m_ptr = (g + 1) % 4;
        end
        if (m_valid && rr) m_count = m_count + 32'd1;
        m_valid = (g >= 0) ? 1'b1 : (rr ? 1'b0 : m_valid);
    endtask

    // Monitor: compares the presented response against the queue head every cycle,
    // which also proves stability during stalls; pops when the consumer takes it.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset_n === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                check("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
                check("rsp_sum", rsp_sum, e.sum);
                check("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flags});
                if (rsp_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        set_req(0, 64'd1, 64'd2, 64'd3, 4'b0000);
        set_req(1, 64'd10, 64'd20, 64'd30, 4'b0000);
        set_req(2, 64'd5, 64'd7, 64'd12, 4'b0000);
        set_req(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'b0111);

        // Reset held with all requests pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_req_ready", {60'd0, req_ready}, 64'd0);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_op_count", {32'd0, op_count}, 64'd0);
        check("reset_rsp_sum", rsp_sum, 64'd0);
        check("reset_rsp_idflags", {58'd0, rsp_id, rsp_flags}, 64'd0);
        req_valid = 4'h0;
        reset_n   = 1'b1;

        // Round-robin with continuous requests: 0,1,2,3,0,1,2,3 back-to-back.
        repeat (8) cycle(4'hF, 1'b1);
        cycle(4'h0, 1'b1);

        // Single add from requester 2.
        cycle(4'b0100, 1'b1);
        cycle(4'h0, 1'b1);

        // Backpressure: pending response held for three stalled cycles.
        cycle(4'hF, 1'b1);
        repeat (3) cycle(4'hF, 1'b0);
        cycle(4'hF, 1'b1);
        cycle(4'h0, 1'b1);

        // Boundary arithmetic.
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101);
        set_req(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010);
        cycle(4'b1010, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'h0, 1'b1);

        // Mid-operation reset drops the in-flight result asynchronously.
        cycle(4'b0001, 1'b0);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_rst_req_ready", {60'd0, req_ready}, 64'd0);
        exp_q.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_count = 32'd0;
        @(negedge clk);
        req_valid = 4'h0;
        reset_n   = 1'b1;

        // After reset: pointer back at 0, counter restarts and the 2-bit copy wraps.
        cycle(4'b0010, 1'b1);
        repeat (4) cycle(4'hF, 1'b1);
        cycle(4'h0, 1'b1);
        cycle(4'h0, 1'b0);
        check("wrap_count_final", {62'd0, w2_op_count}, {62'd0, m_count[1:0]});

        @(negedge clk);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
